mcp3202_scheduler: RTL and testbench
====================================

MCP3202_SCHEDULER -- requirements
Module: mcp3202_scheduler

Interface
REQ-001 SHALL have parameter MIN_GAP, default 64: minimum idle cycles between eng_done and the next eng_start, giving CS-high time of at least 500 ns at 125 MHz.
REQ-002 SHALL have parameter TIMEOUT, default 4095: cycles after eng_start with no eng_done before the conversion is aborted.
REQ-003 SHALL use one clock and an asynchronous, active-low reset. Ports: clk in 1, system clock (125 MHz); rst_n in 1, asynchronous active-low reset.
REQ-004 enable in 1: high permits new grants.
REQ-005 req in 2: per-requester level request, held until that requester's rsp_valid.
REQ-006 req_odd in 2: channel select per requester (0 = CH0, 1 = CH1).
REQ-007 req_sgl in 2: per-requester mode select (1 = single-ended, 0 = differential).
REQ-008 rsp_valid out 2: one-cycle response pulse to the served requester.
REQ-009 rsp_data out 12: conversion result, valid while rsp_valid is high.
REQ-010 rsp_err out 1: timeout flag, valid while rsp_valid is high.
REQ-011 eng_start out 1: one-cycle pulse that launches one engine frame.
REQ-012 eng_sgl out 1 and eng_odd out 1: engine mode and channel, held stable from eng_start until eng_done or abort.
REQ-013 eng_abort out 1: one-cycle pulse that forces the engine back to CS-high.
REQ-014 eng_done in 1: one-cycle pulse from the engine; eng_data in 12 is valid on that cycle.
REQ-015 busy out 1: high in every state except IDLE.
REQ-016 conv_count out 16: count of successful conversions, wrapping at 2^16.

Function
REQ-017 SHALL implement states IDLE, START, WAIT and GAP.
REQ-018 In IDLE with enable=1 and any req bit set, the block SHALL grant one requester, latch its req_odd and req_sgl into eng_odd and eng_sgl, and move to START on the next edge.
REQ-019 Arbitration SHALL be round-robin: when both requesters request, the one not most recently granted wins; after reset requester 0 wins the first tie.
REQ-020 START SHALL last exactly one cycle with eng_start=1, then move to WAIT; the timeout counter SHALL clear on entry to WAIT.
REQ-021 In WAIT, on eng_done the block SHALL drive rsp_data=eng_data, rsp_err=0 and rsp_valid[granted]=1 on the next cycle, increment conv_count, and move to GAP.
REQ-022 In WAIT, when the timeout counter reaches TIMEOUT without eng_done, the block SHALL pulse eng_abort, drive rsp_valid[granted]=1 with rsp_err=1 and rsp_data=0, leave conv_count unchanged, and move to GAP.
REQ-023 If eng_done and the timeout occur on the same cycle, eng_done SHALL win.
REQ-024 eng_done outside WAIT SHALL be ignored.
REQ-025 GAP SHALL last exactly MIN_GAP cycles, then move to IDLE. The earliest next eng_start is therefore MIN_GAP+2 cycles after the eng_done or abort cycle.
REQ-026 enable=0 SHALL block new grants only; a conversion in START, WAIT or GAP SHALL complete normally.
REQ-027 A req that deasserts before its grant SHALL cause no conversion.
REQ-028 A req that deasserts after its grant SHALL still receive its rsp_valid.
REQ-029 Changes to req_odd or req_sgl after the grant SHALL have no effect on the conversion in progress.
REQ-030 At most one rsp_valid bit SHALL be high in any cycle.
REQ-031 After rsp_valid[n], requester n SHALL be eligible again from the next IDLE.
REQ-032 conv_count SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-033 While rst_n=0, the block SHALL be in IDLE with all outputs at 0: busy, eng_start, eng_abort, eng_sgl, eng_odd, rsp_valid, rsp_err, rsp_data=0x000 and conv_count=0x0000.
REQ-034 Reset SHALL set the round-robin pointer so requester 0 wins the first tie, and SHALL clear the gap and timeout counters.
REQ-035 Reset asserted mid-conversion SHALL abandon the conversion silently: no rsp_valid and no eng_abort pulse.
REQ-036 After rst_n rises, the first grant SHALL be possible on the first clock edge at which IDLE sees a request.

Verification
REQ-037 Single request: req=01, req_odd[0]=1, req_sgl[0]=1; engine returns 0xABC after 2000 cycles -> eng_start pulses once with eng_odd=1 and eng_sgl=1, rsp_valid=01, rsp_data=0xABC, rsp_err=0, conv_count=1.
REQ-038 Contention: req=11 held; engine returns 0x111 then 0x222 -> grants in order 0, 1, 0, 1, and consecutive eng_start pulses are at least MIN_GAP+2 cycles apart.
REQ-039 Timeout: grant made, eng_done never asserted -> eng_abort pulses exactly TIMEOUT cycles after entry to WAIT, rsp_valid with rsp_err=1 and rsp_data=0x000, conv_count unchanged.
REQ-040 Simultaneous events: eng_done on the same cycle the timeout is reached -> normal response with rsp_err=0 and no eng_abort.
REQ-041 Enable and withdrawn requests: enable dropped during WAIT -> that response is delivered and no further eng_start occurs; a req withdrawn before its grant -> no eng_start for that requester.
REQ-042 Reset mid-operation: rst_n pulsed low during WAIT -> all outputs are 0 immediately, and no rsp_valid follows when the engine's late eng_done arrives.

Source files
------------

// File: rtl/mcp3202_scheduler.sv
// rtl/mcp3202_scheduler.sv - two-requester round-robin scheduler for an MCP3202 SPI conversion engine
//
// Purpose:
//   Arbitrates between two requesters, launches one engine frame per grant,
//   returns the 12-bit result (or a timeout error) to the granted requester,
//   and enforces a minimum idle gap (CS-high time) between frames.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   enable               high permits new grants
//   req[1:0]             per-requester level request
//   req_odd[1:0]         per-requester channel select (0 = CH0, 1 = CH1)
//   req_sgl[1:0]         per-requester mode (1 = single-ended, 0 = differential)
//   rsp_valid[1:0]       one-cycle response pulse to the served requester
//   rsp_data[11:0]       conversion result, valid with rsp_valid
//   rsp_err              timeout flag, valid with rsp_valid
//   eng_start            one-cycle pulse launching one engine frame
//   eng_sgl, eng_odd     engine mode/channel, stable for the whole frame
//   eng_abort            one-cycle pulse forcing the engine back to CS-high
//   eng_done, eng_data   engine completion pulse and result
//   busy                 high whenever the scheduler is not idle
//   conv_count[15:0]     successful conversions, wrapping at 2^16

module mcp3202_scheduler #(
   parameter int MIN_GAP = 64,
   parameter int TIMEOUT = 4095
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [1:0]  req,
   input  logic [1:0]  req_odd,
   input  logic [1:0]  req_sgl,
   output logic [1:0]  rsp_valid,
   output logic [11:0] rsp_data,
   output logic        rsp_err,
   output logic        eng_start,
   output logic        eng_sgl,
   output logic        eng_odd,
   output logic        eng_abort,
   input  logic        eng_done,
   input  logic [11:0] eng_data,
   output logic        busy,
   output logic [15:0] conv_count
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

   // The abort and response are registered, so the terminal count is one
   // below TIMEOUT: eng_abort then appears exactly TIMEOUT cycles after the
   // first WAIT cycle. Likewise GAP leaves after its MIN_GAP-th cycle.
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] G_LAST = GW'(MIN_GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t        state;
   logic          gnt;        // requester owning the current conversion
   logic          last_gnt;   // most recently granted requester
   logic          pick;       // arbitration winner for this cycle
   logic [TW-1:0] tcnt;
   logic [GW-1:0] gcnt;

   // Round-robin: on a tie the requester not granted last time wins;
   // otherwise the sole requester wins.
   always_comb begin
      pick = 1'b0;
      if (req == 2'b11)
         pick = ~last_gnt;
      else
         pick = req[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         gnt        <= 1'b0;
         last_gnt   <= 1'b1;   // makes requester 0 win the first tie
         tcnt       <= '0;
         gcnt       <= '0;
         busy       <= 1'b0;
         eng_start  <= 1'b0;
         eng_abort  <= 1'b0;
         eng_sgl    <= 1'b0;
         eng_odd    <= 1'b0;
         rsp_valid  <= 2'b00;
         rsp_err    <= 1'b0;
         rsp_data   <= 12'h000;
         conv_count <= 16'h0000;
      end else begin
         // Pulse outputs default low every cycle.
         eng_start <= 1'b0;
         eng_abort <= 1'b0;
         rsp_valid <= 2'b00;
         rsp_err   <= 1'b0;
         rsp_data  <= 12'h000;

         case (state)
            S_IDLE: begin
               if (enable && (req != 2'b00)) begin
                  gnt       <= pick;
                  last_gnt  <= pick;
                  // Mode/channel are captured here so later changes on the
                  // request side cannot disturb the frame in flight.
                  eng_odd   <= req_odd[pick];
                  eng_sgl   <= req_sgl[pick];
                  eng_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_START;
               end
            end

            S_START: begin
               tcnt  <= '0;
               state <= S_WAIT;
            end

            S_WAIT: begin
               // eng_done is tested first so it wins over a same-cycle timeout.
               if (eng_done) begin
                  rsp_valid  <= gnt ? 2'b10 : 2'b01;
                  rsp_data   <= eng_data;
                  conv_count <= conv_count + 16'd1;
                  gcnt       <= '0;
                  state      <= S_GAP;
               end else if (tcnt == T_LAST) begin
                  eng_abort <= 1'b1;
                  rsp_valid <= gnt ? 2'b10 : 2'b01;
                  rsp_err   <= 1'b1;
                  gcnt      <= '0;
                  state     <= S_GAP;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            S_GAP: begin
               // eng_done arriving here (late engine) falls through unused.
               if (gcnt == G_LAST) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  gcnt <= gcnt + GW'(1);
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcp3202_scheduler.sv
// tb/tb_mcp3202_scheduler.sv - self-checking bench for mcp3202_scheduler

module tb_mcp3202_scheduler;

   localparam int MIN_GAP = 64;
   localparam int TIMEOUT = 4095;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  req, req_odd, req_sgl;
   logic [1:0]  rsp_valid;
   logic [11:0] rsp_data;
   logic        rsp_err;
   logic        eng_start, eng_sgl, eng_odd, eng_abort;
   logic        eng_done;
   logic [11:0] eng_data;
   logic        busy;
   logic [15:0] conv_count;

   always #4 clk = ~clk;

   mcp3202_scheduler #(.MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .req(req), .req_odd(req_odd), .req_sgl(req_sgl),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .eng_start(eng_start), .eng_sgl(eng_sgl), .eng_odd(eng_odd),
      .eng_abort(eng_abort), .eng_done(eng_done), .eng_data(eng_data),
      .busy(busy), .conv_count(conv_count)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] outs_now();
      return 64'({busy, eng_start, eng_abort, eng_sgl, eng_odd, rsp_valid,
                  rsp_err, rsp_data, conv_count});
   endfunction

   // ---------------- engine model ----------------
   int          plan_lat[$];
   logic [11:0] plan_dat[$];
   int          eng_idx = 0;
   bit          eng_pending = 0;
   int          eng_due = 0;
   logic [11:0] eng_dval = '0;

   // ---------------- reference model state ----------------
   // Transaction-level view: an outstanding conversion started at s_cyc,
   // ends at the done cycle or s_cyc+TIMEOUT; idle again MIN_GAP cycles later.
   bit          outst = 0;
   int          s_cyc = 0;
   logic        g_exp = 0;
   logic        cap_odd = 0, cap_sgl = 0;
   bit          pend = 0;
   int          pend_cyc = 0;
   logic [11:0] pend_data = '0;
   int          last_end = -1000;
   logic        last_g = 1'b1;
   logic [15:0] exp_count = '0;
   logic [1:0]  prev_req = '0, prev_odd = '0, prev_sgl = '0;
   logic        prev_en = 0, prev_rst = 0, prev_busy = 0;

   task automatic monitor_step();
      logic       exp_start, g, exp_ab, exp_err, busy_exp;
      logic [1:0] exp_rv;
      logic [11:0] exp_dat;
      cyc++;
      if (!rst_n) begin
         chk("reset_outputs", outs_now(), 64'd0);
         outst = 0; pend = 0; last_end = -1000; last_g = 1'b1; exp_count = '0;
         prev_rst = 0; prev_busy = 0;
         prev_req = req; prev_odd = req_odd; prev_sgl = req_sgl; prev_en = enable;
         return;
      end
      exp_start = prev_rst && !prev_busy && prev_en && (prev_req != 2'b00);
      chk("eng_start", 64'(eng_start), 64'(exp_start));
      if (exp_start) begin
         g = (prev_req == 2'b11) ? ~last_g : prev_req[1];
         chk("start_odd", 64'(eng_odd), 64'(prev_odd[g]));
         chk("start_sgl", 64'(eng_sgl), 64'(prev_sgl[g]));
         outst = 1; pend = 0; s_cyc = cyc; g_exp = g; last_g = g;
         cap_odd = prev_odd[g]; cap_sgl = prev_sgl[g];
         eng_pending = 1;
         if (eng_idx < plan_lat.size()) begin
            eng_due  = cyc + plan_lat[eng_idx];
            eng_dval = plan_dat[eng_idx];
            eng_idx++;
         end else begin
            eng_due  = cyc + (($urandom % 25 == 0) ? TIMEOUT + 3 : int'($urandom_range(1, 60)));
            eng_dval = 12'($urandom);
         end
      end else if (outst && !pend) begin
         chk("hold_odd", 64'(eng_odd), 64'(cap_odd));
         chk("hold_sgl", 64'(eng_sgl), 64'(cap_sgl));
      end
      exp_rv = 2'b00; exp_err = 0; exp_ab = 0; exp_dat = '0;
      if (outst && pend && cyc == pend_cyc) begin
         exp_rv = g_exp ? 2'b10 : 2'b01; exp_dat = pend_data;
         exp_count = exp_count + 16'd1; outst = 0; pend = 0;
      end else if (outst && !pend && cyc == s_cyc + TIMEOUT + 1) begin
         exp_rv = g_exp ? 2'b10 : 2'b01; exp_err = 1; exp_ab = 1;
         last_end = s_cyc + TIMEOUT; outst = 0;
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("eng_abort", 64'(eng_abort), 64'(exp_ab));
      if (exp_rv != 2'b00) begin
         chk("rsp_err", 64'(rsp_err), 64'(exp_err));
         chk("rsp_data", 64'(rsp_data), 64'(exp_dat));
      end
      chk("conv_count", 64'(conv_count), 64'(exp_count));
      if (outst && !pend && eng_done && cyc >= s_cyc + 1 && cyc <= s_cyc + TIMEOUT) begin
         pend = 1; pend_cyc = cyc + 1; pend_data = eng_data; last_end = cyc;
      end
      busy_exp = outst || (cyc <= last_end + MIN_GAP);
      chk("busy", 64'(busy), 64'(busy_exp));
      prev_req = req; prev_odd = req_odd; prev_sgl = req_sgl; prev_en = enable;
      prev_rst = 1; prev_busy = busy_exp;
   endtask

   task automatic engine_step();
      if (eng_pending && cyc + 1 == eng_due) begin
         eng_done = 1'b1; eng_data = eng_dval; eng_pending = 0;
      end else begin
         eng_done = 1'b0; eng_data = 12'($urandom);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor_step();
      @(posedge clk);
      #1;
      engine_step();
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 300 && busy; k++) tick();
      chk("wait_idle", 64'(busy), 64'd0);
   endtask

   task automatic wait_start(input string name);
      bit seen;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         tick();
         if (eng_start) seen = 1;
      end
      chk(name, 64'(seen), 64'd1);
   endtask

   task automatic wait_rsp(input int r, input int limit, input string name,
                           output bit got, output logic [11:0] d, output logic e);
      got = 0; d = '0; e = 0;
      for (int k = 0; k < limit && !got; k++) begin
         tick();
         if (rsp_valid[r]) begin got = 1; d = rsp_data; e = rsp_err; end
      end
      chk(name, 64'(got), 64'd1);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_immediate", outs_now(), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        r;
      logic        odd;
      logic        sgl;
      int          lat;
      logic [11:0] data;
      logic        exp_err;
      logic [11:0] exp_data;
      logic [15:0] exp_inc;
   } vec_t;

   vec_t vecs[6];
   int   hold[2];

   initial begin
      bit          got, seen_start, ab_seen;
      int          st_cyc, ab_cyc, nstart, ns, nr;
      logic        st_odd, st_sgl, e;
      logic [11:0] d;
      logic [15:0] cnt0, dlt;
      int          starts[4];
      logic        godd[4], rsp_g[4];
      logic [11:0] rsp_d[4];

      vecs[0] = '{1'b0, 1'b1, 1'b1, 2000,        12'hABC, 1'b0, 12'hABC, 16'd1};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 5,           12'h5A5, 1'b0, 12'h5A5, 16'd1};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1,           12'h001, 1'b0, 12'h001, 16'd1};
      vecs[3] = '{1'b1, 1'b1, 1'b0, TIMEOUT,     12'h7FF, 1'b0, 12'h7FF, 16'd1};
      vecs[4] = '{1'b0, 1'b1, 1'b0, TIMEOUT + 1, 12'h123, 1'b1, 12'h000, 16'd0};
      vecs[5] = '{1'b1, 1'b0, 1'b1, TIMEOUT + 30,12'hFFF, 1'b1, 12'h000, 16'd0};

      rst_n = 1'b0; enable = 1'b0; req = 2'b00; req_odd = 2'b00; req_sgl = 2'b00;
      eng_done = 1'b0; eng_data = 12'h000;
      repeat (3) tick();
      rst_n = 1'b1; enable = 1'b1;
      tick();

      // Table-driven single conversions.
      for (int i = 0; i < 6; i++) begin
         wait_idle();
         plan_lat.push_back(vecs[i].lat);
         plan_dat.push_back(vecs[i].data);
         cnt0 = conv_count;
         req[vecs[i].r] = 1'b1; req_odd[vecs[i].r] = vecs[i].odd; req_sgl[vecs[i].r] = vecs[i].sgl;
         got = 0; seen_start = 0; ab_seen = 0; st_cyc = 0; ab_cyc = 0;
         st_odd = 0; st_sgl = 0; d = '0; e = 0;
         for (int k = 0; k < TIMEOUT + 300 && !got; k++) begin
            tick();
            if (eng_start) begin
               seen_start = 1; st_cyc = cyc; st_odd = eng_odd; st_sgl = eng_sgl;
               req_odd[vecs[i].r] = ~vecs[i].odd; req_sgl[vecs[i].r] = ~vecs[i].sgl;
            end
            if (eng_abort) begin ab_seen = 1; ab_cyc = cyc; end
            if (rsp_valid[vecs[i].r]) begin got = 1; d = rsp_data; e = rsp_err; end
         end
         req[vecs[i].r] = 1'b0;
         dlt = conv_count - cnt0;
         chk($sformatf("vec%0d_start", i), 64'(seen_start), 64'd1);
         chk($sformatf("vec%0d_rsp", i), 64'(got), 64'd1);
         chk($sformatf("vec%0d_odd", i), 64'(st_odd), 64'(vecs[i].odd));
         chk($sformatf("vec%0d_sgl", i), 64'(st_sgl), 64'(vecs[i].sgl));
         chk($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].exp_data));
         chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
         chk($sformatf("vec%0d_abort", i), 64'(ab_seen), 64'(vecs[i].exp_err));
         chk($sformatf("vec%0d_count", i), 64'(dlt), 64'(vecs[i].exp_inc));
         if (vecs[i].exp_err)
            chk($sformatf("vec%0d_abort_time", i), 64'(ab_cyc - st_cyc), 64'(TIMEOUT + 1));
      end

      // Contention after reset: grants 0,1,0,1 with exact gap spacing.
      wait_idle();
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         plan_lat.push_back(10);
         plan_dat.push_back((i % 2 == 1) ? 12'h222 : 12'h111);
      end
      req_odd = 2'b10; req_sgl = 2'b01; req = 2'b11;
      ns = 0; nr = 0;
      for (int k = 0; k < 1500 && nr < 4; k++) begin
         tick();
         if (eng_start && ns < 4) begin starts[ns] = cyc; godd[ns] = eng_odd; ns++; end
         if (rsp_valid != 2'b00 && nr < 4) begin
            rsp_g[nr] = rsp_valid[1]; rsp_d[nr] = rsp_data; nr++;
         end
      end
      req = 2'b00;
      chk("cont_nrsp", 64'(nr), 64'd4);
      chk("cont_nstart", 64'(ns), 64'd4);
      for (int i = 0; i < 4 && i < nr && i < ns; i++) begin
         chk($sformatf("cont_grant%0d", i), 64'(godd[i]), 64'(i % 2));
         chk($sformatf("cont_rsp%0d", i), 64'(rsp_g[i]), 64'(i % 2));
         chk($sformatf("cont_data%0d", i), 64'(rsp_d[i]), (i % 2 == 1) ? 64'h222 : 64'h111);
         if (i > 0) begin
            chk($sformatf("cont_gap_min%0d", i), 64'(starts[i] - starts[i-1] >= MIN_GAP + 2), 64'd1);
            chk($sformatf("cont_gap%0d", i), 64'(starts[i] - starts[i-1]), 64'(10 + MIN_GAP + 2));
         end
      end

      // Enable dropped during WAIT.
      wait_idle();
      plan_lat.push_back(30); plan_dat.push_back(12'h3C3);
      req[0] = 1'b1;
      wait_start("en_start");
      repeat (5) tick();
      enable = 1'b0; req[1] = 1'b1;
      wait_rsp(0, 200, "en_rsp", got, d, e);
      chk("en_data", 64'(d), 64'h3C3);
      req[0] = 1'b0;
      nstart = 0;
      repeat (300) begin tick(); if (eng_start) nstart++; end
      chk("en_no_start", 64'(nstart), 64'd0);
      req[1] = 1'b0;
      tick();
      enable = 1'b1;
      nstart = 0;
      repeat (100) begin tick(); if (eng_start) nstart++; end
      chk("withdrawn_idle", 64'(nstart), 64'd0);

      // Request withdrawn while another conversion is running.
      plan_lat.push_back(20); plan_dat.push_back(12'h0F0);
      req[0] = 1'b1;
      wait_start("wd_start");
      repeat (3) tick();
      req[1] = 1'b1;
      wait_rsp(0, 100, "wd_rsp", got, d, e);
      chk("wd_data", 64'(d), 64'h0F0);
      req = 2'b00;
      nstart = 0;
      repeat (200) begin tick(); if (eng_start) nstart++; end
      chk("wd_no_start", 64'(nstart), 64'd0);

      // Reset during WAIT; the engine's late eng_done must be ignored.
      plan_lat.push_back(200); plan_dat.push_back(12'h5C5);
      req[0] = 1'b1;
      wait_start("rst_start");
      repeat (20) tick();
      req[0] = 1'b0;
      pulse_reset();
      nstart = 0;
      repeat (300) begin
         tick();
         if (rsp_valid != 2'b00 || eng_abort || eng_start) nstart++;
      end
      chk("rst_silent", 64'(nstart), 64'd0);

      // Randomized traffic against the reference model.
      hold[0] = 0; hold[1] = 0;
      enable = 1'b1;
      for (int c = 0; c < 15000; c++) begin
         tick();
         for (int r = 0; r < 2; r++) begin
            if (req[r] && rsp_valid[r]) begin
               req[r] = 1'b0; hold[r] = int'($urandom_range(0, 3));
            end else if (req[r]) begin
               if ($urandom % 64 == 0) req[r] = 1'b0;
            end else if (hold[r] > 0) begin
               hold[r]--;
            end else if ($urandom % 4 == 0) begin
               req[r] = 1'b1; req_odd[r] = 1'($urandom); req_sgl[r] = 1'($urandom);
            end
            if ($urandom % 8 == 0) req_odd[r] = 1'($urandom);
            if ($urandom % 8 == 0) req_sgl[r] = 1'($urandom);
         end
         if ($urandom % 400 == 0) enable = ~enable;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
